lshift_iter32: RTL and testbench

//   Multi-cycle 32-bit left shifter. Companion to the ALU's combinational right-shift unit.

---
 rtl/alu_defs_pkg.sv | 25 ++
 rtl/lshift_iter32.sv | 137 +++++++++++++
 tb/tb_lshift_iter32.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_defs_pkg.sv
// ---------------------------------------------------------------------------
// alu_defs : shared definitions for the ALU shift companions.
//   WIDTH    data width of operands and results
//   SHAMT_W  number of shift-amount bits taken from the B operand
//   state_t  FSM encoding used by lshift_iter32
//   shl1     single-step left shift with an explicit fill bit
// ---------------------------------------------------------------------------
package alu_defs;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One shift step: drop the MSB, insert fill at the LSB.
    function automatic logic [WIDTH-1:0] shl1(input logic [WIDTH-1:0] v,
                                              input logic             fill);
        return {v[WIDTH-2:0], fill};
    endfunction

endpackage

// File: rtl/lshift_iter32.sv
// ---------------------------------------------------------------------------
// lshift_iter32 : multi-cycle left shifter, one bit position per clock.
//   Operand A is shifted left by B[SHAMT_W-1:0] positions (modulo WIDTH);
//   upper bits of B are ignored. Launch with start while idle; busy is high
//   while shifting, done pulses for one cycle when C is valid. C holds its
//   value until the next accepted start.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      launch request, honoured only in IDLE
//   rot    in   1      rotate select (only with LSHIFT_ROTATE_EN)
//   A      in   WIDTH  operand, latched on accepted start
//   B      in   WIDTH  shift amount, low SHAMT_W bits used
//   C      out  WIDTH  result register
//   busy   out  1      high in SHIFT state
//   done   out  1      one-cycle completion pulse
//
// Build option
//   LSHIFT_ROTATE_EN : adds the rot input; rot=1 feeds the outgoing MSB back
//                      into the LSB (rotate left), rot=0 shifts in zeros.
//                      Undefined: logical shift only, no rot port.
// ---------------------------------------------------------------------------
module lshift_iter32
    import alu_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef LSHIFT_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             busy,
    output logic             done
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SHAMT_W-1:0]   r_count;
    logic [SHAMT_W-1:0]   w_count_nxt;
    logic [WIDTH-1:0]     r_c;
    logic [WIDTH-1:0]     w_c_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_fill;
    logic                 w_unused_b;

    // Upper shift-amount bits are architecturally ignored.
    assign w_unused_b = ^B[WIDTH-1:SHAMT_W];

`ifdef LSHIFT_ROTATE_EN
    logic r_rot;
    logic w_rot_nxt;

    // Rotate re-injects the bit leaving the MSB; logical shift injects zero.
    assign w_fill = r_rot & r_c[WIDTH-1];
`else
    assign w_fill = 1'b0;
`endif

    // Next-state, next-count and next-result logic for the shift FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_c_nxt     = r_c;
`ifdef LSHIFT_ROTATE_EN
        w_rot_nxt   = r_rot;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_count_nxt = B[SHAMT_W-1:0];
                    w_c_nxt     = A;
`ifdef LSHIFT_ROTATE_EN
                    w_rot_nxt   = rot;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The count==0 cycle is spent in SHIFT, giving n+1 cycles of busy.
                if (r_count != {SHAMT_W{1'b0}}) begin
                    w_c_nxt     = shl1(r_c, w_fill);
                    w_count_nxt = r_count - SHAMT_W'(1);
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately not sampled here; a held start relaunches from IDLE.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= {SHAMT_W{1'b0}};
            r_c     <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_c     <= w_c_nxt;
            // Flags decoded from the next state so they align with r_state.
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

`ifdef LSHIFT_ROTATE_EN
    // Rotate mode is captured alongside the operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rot <= 1'b0;
        end else begin
            r_rot <= w_rot_nxt;
        end
    end
`endif

    assign C    = r_c;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_lshift_iter32.sv
// ---------------------------------------------------------------------------
// tb_lshift_iter32 : self-checking bench for lshift_iter32.
//   Table of operand/expected-result records plus hand-written sequences for
//   ignored start, held start and mid-operation reset. Expected results and
//   completion cycles are queued at launch and checked when done pulses.
//   Compile with +define+LSHIFT_ROTATE_EN to exercise rotate mode.
// ---------------------------------------------------------------------------
module tb_lshift_iter32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        rot_i;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] C;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        rot;
        logic [31:0] exp_c;
    } vec_t;

    typedef struct {
        logic [31:0] exp_c;
        int          due;
    } exp_t;

    vec_t vecs[9];
    exp_t q[$];
    int   n_checks;
    int   n_fail;
    int   cyc;

    lshift_iter32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef LSHIFT_ROTATE_EN
        .rot   (rot_i),
`endif
        .A     (A),
        .B     (B),
        .C     (C),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: samples 2 time units after every rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (!rst) begin
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("result", C, e.exp_c);
                    chk("latency_cycle", 32'(cyc), 32'(e.due));
                    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                end
            end else if (q.size() > 0 && cyc > q[0].due) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: no done by cycle %0d, expected at %0d", cyc, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    // Called just after a rising edge with the DUT idle.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic r, input logic [31:0] exp);
        A     = a;
        B     = b;
        rot_i = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{exp_c: exp, due: cyc + int'(b[4:0]) + 1});
        start = 1'b0;
    endtask

    // Wait for all queued results, then one more edge so the FSM is back in IDLE.
    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #3;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: %0d results still pending at cycle %0d", q.size(), cyc);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        rot_i    = 1'b0;
        A        = 32'd0;
        B        = 32'd0;

        vecs[0] = '{a: 32'h00C0EC4E, b: 32'd5,          rot: 1'b0, exp_c: 32'h181D89C0};
        vecs[1] = '{a: 32'hDEADBEEF, b: 32'd0,          rot: 1'b0, exp_c: 32'hDEADBEEF};
        vecs[2] = '{a: 32'h00000001, b: 32'd31,         rot: 1'b0, exp_c: 32'h80000000};
        vecs[3] = '{a: 32'h00000001, b: 32'd37,         rot: 1'b0, exp_c: 32'h00000020};
        vecs[4] = '{a: 32'h80000001, b: 32'd1,          rot: 1'b0, exp_c: 32'h00000002};
        vecs[6] = '{a: 32'hFFFFFFFF, b: 32'd31,         rot: 1'b0, exp_c: 32'h80000000};
`ifdef LSHIFT_ROTATE_EN
        vecs[5] = '{a: 32'h80000001, b: 32'd1,          rot: 1'b1, exp_c: 32'h00000003};
        vecs[7] = '{a: 32'hF0000000, b: 32'hFFFFFFE4,   rot: 1'b1, exp_c: 32'h0000000F};
        vecs[8] = '{a: 32'h80000001, b: 32'd4,          rot: 1'b1, exp_c: 32'h00000018};
`else
        vecs[5] = '{a: 32'h80000001, b: 32'd1,          rot: 1'b1, exp_c: 32'h00000002};
        vecs[7] = '{a: 32'hF0000000, b: 32'hFFFFFFE4,   rot: 1'b1, exp_c: 32'h00000000};
        vecs[8] = '{a: 32'h80000001, b: 32'd4,          rot: 1'b1, exp_c: 32'h00000010};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_C", C, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].rot, vecs[i].exp_c);
            wait_idle();
            chk("C_hold", C, vecs[i].exp_c);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end

        // start pulsed while busy is ignored
        launch(32'h0000FFFF, 32'd20, 1'b0, 32'hFFF00000);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_mid_op", {31'd0, busy}, 32'd1);
        A     = 32'h00001234;
        B     = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk("ignored_start_hold", C, 32'hFFF00000);

        // start held high: relaunch on the first IDLE edge after DONE
        A     = 32'd1;
        B     = 32'd2;
        rot_i = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        q.push_back('{exp_c: 32'h00000004, due: k + 3});
        q.push_back('{exp_c: 32'h00000038, due: k + 9});
        A = 32'd7;
        B = 32'd3;
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #3;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held_no_relaunch", {31'd0, busy}, 32'd0);
        chk("held_result_hold", C, 32'h00000038);

        // Reset in the middle of an operation
        launch(32'h0000ABCD, 32'd20, 1'b0, 32'hBCD00000);
        repeat (7) @(posedge clk);
        #4;
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        q.delete();
        chk("midrst_C", C, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;
        launch(32'd3, 32'd2, 1'b0, 32'h0000000C);
        wait_idle();
        chk("after_rst_hold", C, 32'h0000000C);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
